// File: rtl/lsu_align_stage.sv
// lsu_align_stage: load/store alignment in front of a word-organised data memory.
// Stores go out as a word address plus byte enables and lane-replicated data.
// Loads return one word; the addressed byte or halfword is extracted, extended
// and registered for MEM/WB.
//
// Optional build macro LSU_MISALIGN_TRAP_EN:
//   defined   - misaligned accesses make no memory traffic, set a sticky flag,
//               and a misaligned load returns 0.
//   undefined - the low address bits are ignored for halfword/word accesses
//               and misaligned is tied low.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | ready for a request
// ST_ISSUE   | byte enables and write data on the memory port, store_done
// LD_ISSUE   | word address on the memory port, no write
// LD_CAPTURE | memory word valid, extracted result registered
// RESP       | resp_valid pulse, resp_rdata holds the result
module lsu_align_stage #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DM_ADDRESS-1:0] a,
  input  logic [DATA_W-1:0]     wd,
  input  logic [2:0]            Funct3,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [3:0]            mem_wr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  store_done,
  output logic                  misaligned
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ST_ISSUE,
    S_LD_ISSUE,
    S_LD_CAPTURE,
    S_RESP
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_accept;
  logic                  w_drop;      // captured access is suppressed
  logic                  w_req_drop;  // incoming access will be suppressed
  logic [1:0]            r_off;
  logic [DATA_W-1:0]     r_wd;
  logic [2:0]            r_funct3;
  logic [DM_ADDRESS-1:0] r_mem_addr;
  logic [DATA_W-1:0]     r_resp_rdata;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_W-1:0]     w_ext;

  // MemRead wins when both op bits are set, so any accepted request with
  // MemRead high is a load.
  assign w_accept = req_valid && (r_state == S_IDLE) && (MemRead || MemWrite);

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_req_mis;
  logic r_mis;
  logic r_misaligned;

  // Funct3[1:0]=01 is a halfword, Funct3[1]=1 a word; bytes are always aligned.
  assign w_req_mis  = ((Funct3[1:0] == 2'b01) && a[0]) ||
                      (Funct3[1] && (a[1:0] != 2'b00));
  assign w_req_drop = w_req_mis;
  assign w_drop     = r_mis;
  assign misaligned = r_misaligned;

  // Per-access misalignment capture and the sticky flag seen by software.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mis        <= 1'b0;
      r_misaligned <= 1'b0;
    end else if (w_accept) begin
      r_mis <= w_req_mis;
      if (w_req_mis) r_misaligned <= 1'b1;
    end
  end
`else
  assign w_req_drop = 1'b0;
  assign w_drop     = 1'b0;
  assign misaligned = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state sequencing; every non-idle state lasts exactly one cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (w_accept) w_next = MemRead ? S_LD_ISSUE : S_ST_ISSUE;
      S_ST_ISSUE:   w_next = S_IDLE;
      S_LD_ISSUE:   w_next = S_LD_CAPTURE;
      S_LD_CAPTURE: w_next = S_RESP;
      S_RESP:       w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  // Request capture; mem_addr only moves for accesses that reach memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_off      <= '0;
      r_wd       <= '0;
      r_funct3   <= '0;
      r_mem_addr <= '0;
    end else if (w_accept) begin
      r_off    <= a[1:0];
      r_wd     <= wd;
      r_funct3 <= Funct3;
      if (!w_req_drop) r_mem_addr <= {a[DM_ADDRESS-1:2], 2'b00};
    end
  end

  // Store lane steering; halfword/word enables ignore the low offset bits.
  always_comb begin
    mem_wr    = 4'b0000;
    mem_wdata = '0;
    if ((r_state == S_ST_ISSUE) && !w_drop) begin
      case (r_funct3)
        3'b000: begin
          mem_wr    = 4'b0001 << r_off;
          mem_wdata = {(DATA_W/8){r_wd[7:0]}};
        end
        3'b001: begin
          mem_wr    = 4'b0011 << {r_off[1], 1'b0};
          mem_wdata = {(DATA_W/16){r_wd[15:0]}};
        end
        3'b010: begin
          mem_wr    = 4'b1111;
          mem_wdata = r_wd;
        end
        default: begin
          mem_wr    = 4'b0000;
          mem_wdata = '0;
        end
      endcase
    end
  end

  // Load extraction from the returned word; Funct3[2] selects zero-extension.
  always_comb begin
    w_byte = mem_rdata[{r_off, 3'b000} +: 8];
    w_half = mem_rdata[{r_off[1], 4'b0000} +: 16];
    case (r_funct3[1:0])
      2'b00:   w_ext = r_funct3[2] ? {{(DATA_W-8){1'b0}}, w_byte}
                                   : {{(DATA_W-8){w_byte[7]}}, w_byte};
      2'b01:   w_ext = r_funct3[2] ? {{(DATA_W-16){1'b0}}, w_half}
                                   : {{(DATA_W-16){w_half[15]}}, w_half};
      default: w_ext = mem_rdata;
    endcase
  end

  // Load result register; holds until the next load reaches LD_CAPTURE.
  always_ff @(posedge clk) begin
    if (reset)                          r_resp_rdata <= '0;
    else if (r_state == S_LD_CAPTURE)   r_resp_rdata <= w_drop ? '0 : w_ext;
  end

  assign req_ready  = (r_state == S_IDLE);
  assign store_done = (r_state == S_ST_ISSUE);
  assign resp_valid = (r_state == S_RESP);
  assign mem_addr   = r_mem_addr;
  assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_lsu_align_stage.sv
// Bench for lsu_align_stage: directed cases with literal expectations, then
// random traffic against a transaction-level model that schedules what each
// output must show on each cycle. The memory behind the DUT is a byte array
// written from the DUT's own port; the model keeps a separate byte image.
module tb_lsu_align_stage;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int NC = 4096;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          MemRead;
  logic          MemWrite;
  logic [AW-1:0] a;
  logic [DW-1:0] wd;
  logic [2:0]    Funct3;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          store_done;
  logic          misaligned;

  always #5 clk = ~clk;

  lsu_align_stage #(.DM_ADDRESS(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .a(a), .wd(wd), .Funct3(Funct3),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .store_done(store_done), .misaligned(misaligned)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Physical memory seen by the DUT: byte-enable writes, one-cycle read.
  bit [7:0]      pmem [512];
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_a = '0;
  logic [DW-1:0] poke_d = '0;
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_wr[i]) pmem[int'(mem_addr) + i] <= mem_wdata[8*i +: 8];
      if (poke_en)   pmem[int'(poke_a) + i]   <= poke_d[8*i +: 8];
    end
    mem_rdata <= {pmem[int'(mem_addr) + 3], pmem[int'(mem_addr) + 2],
                  pmem[int'(mem_addr) + 1], pmem[int'(mem_addr)]};
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Model: per-cycle schedule of expected outputs plus a byte image of memory.
  bit        e_busy [NC];
  bit        e_done [NC];
  bit        e_wdx  [NC];
  bit        e_rv   [NC];
  bit        e_aset [NC];
  bit        e_rset [NC];
  bit        e_mset [NC];
  bit        e_rst  [NC];
  bit [3:0]  e_wr   [NC];
  bit [31:0] e_wd   [NC];
  bit [31:0] e_rval [NC];
  bit [8:0]  e_aval [NC];
  bit [7:0]  mmem   [512];
  int        free_cyc = 0;

  function automatic bit [31:0] load_val(input int ad, input bit [2:0] f);
    int base;
    bit [31:0] v;
    case (f[1:0])
      2'b00: begin
        v = 32'(mmem[ad]);
        if (!f[2] && v >= 128) v = v - 256;
      end
      2'b01: begin
        base = ad - ad % 2;
        v = 32'(mmem[base]) + 256 * 32'(mmem[base + 1]);
        if (!f[2] && v >= 32768) v = v - 65536;
      end
      default: begin
        base = ad - ad % 4;
        v = 32'(mmem[base]) + 256 * 32'(mmem[base + 1]) +
            65536 * 32'(mmem[base + 2]) + 16777216 * 32'(mmem[base + 3]);
      end
    endcase
    return v;
  endfunction

  task automatic model_accept(input int t, input bit ld, input int ad,
                              input bit [31:0] d, input bit [2:0] f);
    bit mis;
    bit drop;
    int base;
    mis  = (f[1:0] == 2'b01 && ad % 2 == 1) || (f[1] && ad % 4 != 0);
    drop = TRAP && mis;
    if (drop) e_mset[t+1] = 1'b1;
    else begin
      e_aset[t+1] = 1'b1;
      e_aval[t+1] = 9'(ad - ad % 4);
    end
    if (ld) begin
      for (int k = 1; k <= 3; k++) e_busy[t+k] = 1'b1;
      free_cyc    = t + 4;
      e_rv[t+3]   = 1'b1;
      e_rset[t+3] = 1'b1;
      e_rval[t+3] = drop ? 32'h0 : load_val(ad, f);
    end else begin
      e_busy[t+1] = 1'b1;
      free_cyc    = t + 2;
      e_done[t+1] = 1'b1;
      e_wr[t+1]   = 4'h0;
      e_wdx[t+1]  = 1'b1;
      if (!drop) begin
        case (f)
          3'b000: begin
            mmem[ad]    = d[7:0];
            e_wr[t+1]   = 4'(1 << (ad % 4));
            e_wd[t+1]   = 32'(d[7:0]) * 32'h01010101;
            e_wdx[t+1]  = 1'b0;
          end
          3'b001: begin
            base = ad - ad % 2;
            mmem[base]     = d[7:0];
            mmem[base + 1] = d[15:8];
            e_wr[t+1]  = 4'(3 << (base % 4));
            e_wd[t+1]  = 32'(d[15:0]) * 32'h00010001;
            e_wdx[t+1] = 1'b0;
          end
          3'b010: begin
            base = ad - ad % 4;
            for (int k = 0; k < 4; k++) mmem[base + k] = d[8*k +: 8];
            e_wr[t+1]  = 4'hF;
            e_wd[t+1]  = d;
            e_wdx[t+1] = 1'b0;
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic model_reset(input int r);
    for (int k = 1; k <= 4; k++) begin
      e_busy[r+k] = 0; e_done[r+k] = 0; e_wdx[r+k] = 0; e_rv[r+k] = 0;
      e_aset[r+k] = 0; e_rset[r+k] = 0; e_mset[r+k] = 0; e_rst[r+k] = 0;
      e_wr[r+k] = 0; e_wd[r+k] = 0; e_rval[r+k] = 0; e_aval[r+k] = 0;
    end
    e_rst[r+1] = 1'b1;
    free_cyc   = r + 1;
  endtask

  // Per-cycle comparison against the model schedule.
  bit [8:0]  cur_addr = '0;
  bit [31:0] cur_resp = '0;
  bit        cur_mis  = 1'b0;
  always @(negedge clk) begin
    if (cyc >= 2 && cyc < NC - 4) begin
      if (e_rst[cyc]) begin
        cur_addr = '0;
        cur_resp = '0;
        cur_mis  = 1'b0;
      end
      if (e_aset[cyc]) cur_addr = e_aval[cyc];
      if (e_rset[cyc]) cur_resp = e_rval[cyc];
      if (e_mset[cyc]) cur_mis = 1'b1;
      chk("req_ready",  32'(req_ready),  32'(!e_busy[cyc]));
      chk("store_done", 32'(store_done), 32'(e_done[cyc]));
      chk("mem_wr",     32'(mem_wr),     32'(e_wr[cyc]));
      if (!e_wdx[cyc]) chk("mem_wdata", mem_wdata, e_wd[cyc]);
      chk("resp_valid", 32'(resp_valid), 32'(e_rv[cyc]));
      chk("resp_rdata", resp_rdata,      cur_resp);
      chk("mem_addr",   32'(mem_addr),   32'(cur_addr));
      chk("misaligned", 32'(misaligned), 32'(cur_mis));
    end
  end

  task automatic apply(input bit v, input bit rd, input bit wr, input int ad,
                       input bit [31:0] d, input bit [2:0] f, input bit rs);
    req_valid = v; MemRead = rd; MemWrite = wr;
    a = 9'(ad); wd = d; Funct3 = f; reset = rs;
    if (rs) model_reset(cyc);
    else if (v && (rd || wr) && cyc >= free_cyc) model_accept(cyc, rd, ad, d, f);
    @(posedge clk);
    #1;
    poke_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) apply(1'b0, 1'b0, 1'b0, 0, 32'h0, 3'b000, 1'b0);
  endtask

  task automatic poke(input int ad, input bit [31:0] val);
    for (int k = 0; k < 4; k++) mmem[ad + k] = val[8*k +: 8];
    poke_a  = 9'(ad);
    poke_d  = val;
    poke_en = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: bench exceeded its time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    a = '0; wd = '0; Funct3 = '0;
    @(posedge clk);
    #1;
    apply(1'b0, 1'b0, 1'b0, 0, 32'h0, 3'b000, 1'b1);
    @(negedge clk);
    chk("rst req_ready",  32'(req_ready),  32'h1);
    chk("rst resp_valid", 32'(resp_valid), 32'h0);
    chk("rst mem_wr",     32'(mem_wr),     32'h0);
    chk("rst mem_addr",   32'(mem_addr),   32'h0);
    idle(1);

    // SB a=0x005
    apply(1'b1, 1'b0, 1'b1, 'h005, 32'h000000AB, 3'b000, 1'b0);
    @(negedge clk);
    chk("sb mem_addr",   32'(mem_addr),   32'h004);
    chk("sb mem_wr",     32'(mem_wr),     32'h2);
    chk("sb mem_wdata",  mem_wdata,       32'hABABABAB);
    chk("sb store_done", 32'(store_done), 32'h1);
    idle(1);

    // LB / LBU a=0x007
    poke('h004, 32'h80FF1234);
    apply(1'b1, 1'b1, 1'b0, 'h007, 32'h0, 3'b000, 1'b0);
    idle(2);
    @(negedge clk);
    chk("lb resp_valid", 32'(resp_valid), 32'h1);
    chk("lb resp_rdata", resp_rdata,      32'hFFFFFF80);
    idle(1);
    apply(1'b1, 1'b1, 1'b0, 'h007, 32'h0, 3'b100, 1'b0);
    idle(2);
    @(negedge clk);
    chk("lbu resp_rdata", resp_rdata, 32'h00000080);
    idle(1);

    // LH a=0x002, LHU a=0x000
    poke('h000, 32'h80017FFF);
    apply(1'b1, 1'b1, 1'b0, 'h002, 32'h0, 3'b001, 1'b0);
    idle(2);
    @(negedge clk);
    chk("lh resp_rdata", resp_rdata, 32'hFFFF8001);
    idle(1);
    apply(1'b1, 1'b1, 1'b0, 'h000, 32'h0, 3'b101, 1'b0);
    idle(2);
    @(negedge clk);
    chk("lhu resp_rdata", resp_rdata, 32'h00007FFF);
    idle(1);

    // SW then LW back-to-back; the LW offered during ST_ISSUE is ignored
    apply(1'b1, 1'b0, 1'b1, 'h010, 32'h12345678, 3'b010, 1'b0);
    @(negedge clk);
    chk("sw mem_wr",    32'(mem_wr),    32'hF);
    chk("sw req_ready", 32'(req_ready), 32'h0);
    apply(1'b1, 1'b1, 1'b0, 'h010, 32'h0, 3'b010, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 'h010, 32'h0, 3'b010, 1'b0);
    @(negedge clk);
    chk("lw accepted", 32'(req_ready), 32'h0);
    idle(2);
    @(negedge clk);
    chk("lw resp_rdata", resp_rdata, 32'h12345678);
    idle(1);

    // LW a=0x006
    poke('h004, 32'hCAFEF00D);
    apply(1'b1, 1'b1, 1'b0, 'h006, 32'h0, 3'b010, 1'b0);
    @(negedge clk);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis flag",     32'(misaligned), 32'h1);
    chk("mis mem_addr", 32'(mem_addr),   32'h010);
`else
    chk("mis flag",     32'(misaligned), 32'h0);
    chk("mis mem_addr", 32'(mem_addr),   32'h004);
`endif
    idle(2);
    @(negedge clk);
    chk("mis resp_valid", 32'(resp_valid), 32'h1);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis resp_rdata", resp_rdata, 32'h0);
`else
    chk("mis resp_rdata", resp_rdata, 32'hCAFEF00D);
`endif
    idle(1);

    // Reset while in LD_CAPTURE
    apply(1'b1, 1'b1, 1'b0, 'h010, 32'h0, 3'b010, 1'b0);
    idle(1);
    apply(1'b0, 1'b0, 1'b0, 0, 32'h0, 3'b000, 1'b1);
    @(negedge clk);
    chk("rstcap req_ready",  32'(req_ready),  32'h1);
    chk("rstcap resp_valid", 32'(resp_valid), 32'h0);
    chk("rstcap mem_wr",     32'(mem_wr),     32'h0);
    chk("rstcap resp_rdata", resp_rdata,      32'h0);
    idle(3);

    // Random traffic
    for (int n = 0; n < 2500 && cyc < NC - 12; n++) begin
      if ($urandom_range(0, 99) == 0)
        apply(1'b0, 1'b0, 1'b0, 0, 32'h0, 3'b000, 1'b1);
      else
        apply($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 511)),
              $urandom, 3'($urandom_range(0, 7)), 1'b0);
    end
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_align_stage.md
Name: lsu_align_stage

Overview:
Load/store alignment stage placed directly upstream of the word-organised data memory in the MEM stage of the RISC-V pipeline.
- Accepts one access per handshake: ALU address, store data and Funct3.
- Drives a word-aligned address, per-byte write enables and lane-replicated write data to the memory.
- On loads, extracts the addressed byte or halfword from the returned word, sign- or zero-extends it, and presents a registered result for MEM/WB.

Parameters:
DM_ADDRESS, 9, width of byte address into data memory
DATA_W, 32, data word width (fixed at 32; other values unsupported)

Ports:
clk  input  1  clock, rising-edge
reset  input  1  synchronous active-high reset
req_valid  input  1  access request present
req_ready  output  1  stage can accept a request
MemRead  input  1  request is a load (control unit)
MemWrite  input  1  request is a store (control unit)
a  input  DM_ADDRESS  byte address from ALU
wd  input  DATA_W  store data (rs2)
Funct3  input  3  instruction bits 14:12
mem_addr  output  DM_ADDRESS  word-aligned address to memory, bits [1:0]=0
mem_wr  output  4  byte write enables to memory
mem_wdata  output  DATA_W  lane-replicated write data
mem_rdata  input  DATA_W  memory read word, valid the cycle after mem_addr is presented
resp_valid  output  1  one-cycle pulse, load result valid
resp_rdata  output  DATA_W  extended load result
store_done  output  1  one-cycle pulse, store issued
misaligned  output  1  sticky misalignment flag

Behaviour:
- Reset: all outputs 0 except req_ready=1; state IDLE; internal captures cleared.
- Reset asserted in any state returns the block to IDLE at that edge. Pending loads and stores are dropped; no mem_wr or resp_valid pulse follows.
- req_ready=1 only in IDLE.
- Accept condition: req_valid & req_ready & (MemRead | MemWrite).
- MemRead=1 and MemWrite=1 together: treated as a load only.
- Request with neither MemRead nor MemWrite: ignored, stays IDLE.
- On accept, register a, wd, Funct3 and the op.
- States:
  - IDLE: on load accept → LD_ISSUE; on store accept → ST_ISSUE.
  - ST_ISSUE (1 cycle): mem_addr={a[DM_ADDRESS-1:2],2'b00}, mem_wr and mem_wdata per Funct3, store_done=1 → IDLE. Store latency: accept at T, write at T+1.
  - LD_ISSUE (1 cycle): mem_addr driven, mem_wr=0 → LD_CAPTURE.
  - LD_CAPTURE (1 cycle): sample mem_rdata → RESP.
  - RESP (1 cycle): resp_valid=1, resp_rdata held until the next load's RESP → IDLE. Load latency: accept at T, resp_valid at T+3; next accept possible at T+4.
- mem_wr and mem_wdata are 0 outside ST_ISSUE. mem_addr holds its last value.
- Store lanes, with off=a[1:0]:
  - SB (000): mem_wr=4'b0001<<off, mem_wdata={4{wd[7:0]}}.
  - SH (001): mem_wr=4'b0011<<{off[1],1'b0}, mem_wdata={2{wd[15:0]}}.
  - SW (010): mem_wr=4'b1111, mem_wdata=wd.
  - Any other store Funct3: mem_wr=0, store_done still pulses.
- Load extraction:
  - LB (000): byte at lane off, sign-extended from its bit 7.
  - LBU (100): same byte, zero-extended.
  - LH (001): halfword at lanes {off[1],0}/{off[1],1}, sign-extended from bit 15.
  - LHU (101): same halfword, zero-extended.
  - LW (010) and any other Funct3: full word.
- Misaligned access: halfword with a[0]=1, or word with a[1:0]≠0. Byte accesses are never misaligned. Handling per Optional Feature.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined:
  - A misaligned access is accepted but produces no memory traffic.
  - misaligned is set and held until reset.
  - A load still passes through the full state sequence with mem_addr unchanged, and pulses resp_valid at T+3 with resp_rdata=0.
  - A store skips the write (mem_wr=0) but store_done still pulses at T+1.
- Undefined:
  - misaligned is tied 0.
  - Low address bits are forced: halfword uses off[0]=0, word uses off=0.
  - The access then proceeds normally.

Test Plan:
- SB, a=0x005, wd=0x000000AB → at T+1: mem_addr=0x004, mem_wr=4'b0010, mem_wdata=0xABABABAB, store_done=1.
- LB, a=0x007, mem_rdata=0x80FF1234 → resp_valid at T+3, resp_rdata=0xFFFFFF80. Same with LBU → 0x00000080.
- LH, a=0x002, mem_rdata=0x80017FFF → resp_rdata=0xFFFF8001. LHU, a=0x000 → 0x00007FFF.
- SW, a=0x010, wd=0x12345678, followed immediately by LW, a=0x010 → mem_wr=4'b1111 at T+1; load accepted at T+2; req_ready=0 during ST_ISSUE.
- LW, a=0x006:
  - Macro defined → no valid memory read, misaligned=1, resp_rdata=0.
  - Macro undefined → mem_addr=0x004, resp_rdata=mem_rdata.
- reset=1 during LD_CAPTURE → next cycle IDLE, req_ready=1, no resp_valid pulse, mem_wr=0.
